// File: rtl/load_store_unit.sv
// Load/store stage: forwards non-memory results, drives a single-outstanding
// data-memory request, and formats load data / store lanes for writeback.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wr_enable,
  input  logic        ex_mem_to_reg,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_valid,
  output logic [4:0]  mem_rd,
  output logic        mem_wr_enable,
  output logic        mem_mem_to_reg,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_read_data,
  output logic        mem_exc
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state;

  logic [4:0]  rd_p0;
  logic        wr_en_p0;
  logic        mem_to_reg_p0;
  logic [2:0]  funct3_p0;
  logic [31:0] alu_p0;

  logic is_mem;
  logic illegal;
  logic misaligned;
  logic exc;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << lane;
      2'b01:   store_be = 4'b0011 << lane;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_wdata = {4{d[7:0]}};
      2'b01:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend per funct3.
  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] rdata);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = rdata >> {lane, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  load_format = {{24{b[7]}}, b};
      3'b001:  load_format = {{16{h[15]}}, h};
      3'b100:  load_format = {24'h0, b};
      3'b101:  load_format = {16'h0, h};
      default: load_format = rdata;
    endcase
  endfunction

  assign is_mem   = ex_mem_read | ex_mem_write;
  assign ex_ready = (state == IDLE);

  always_comb begin
    illegal = 1'b0;
    if (ex_mem_read && ex_mem_write)
      illegal = 1'b1;
    else if (ex_mem_read)
      illegal = !(ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (ex_mem_write)
      illegal = !(ex_funct3 inside {3'b000, 3'b001, 3'b010});
  end

  assign misaligned = ((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]) ||
                      ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00));
  assign exc = is_mem && (illegal || misaligned);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rd_p0          <= '0;
      wr_en_p0       <= 1'b0;
      mem_to_reg_p0  <= 1'b0;
      funct3_p0      <= '0;
      alu_p0         <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= '0;
      mem_valid      <= 1'b0;
      mem_rd         <= '0;
      mem_wr_enable  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_alu_result <= '0;
      mem_read_data  <= '0;
      mem_exc        <= 1'b0;
    end else begin
      mem_valid <= 1'b0;
      case (state)
        // p0: accept from execute; non-memory and faulting ops retire directly
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem || exc) begin
              mem_valid      <= 1'b1;
              mem_rd         <= ex_rd;
              mem_wr_enable  <= ex_wr_enable && !exc;
              mem_mem_to_reg <= ex_mem_to_reg;
              mem_alu_result <= ex_alu_result;
              mem_exc        <= exc;
            end else begin
              rd_p0         <= ex_rd;
              wr_en_p0      <= ex_wr_enable;
              mem_to_reg_p0 <= ex_mem_to_reg;
              funct3_p0     <= ex_funct3;
              alu_p0        <= ex_alu_result;
              dmem_req      <= 1'b1;
              dmem_we       <= ex_mem_write;
              dmem_addr     <= {ex_alu_result[31:2], 2'b00};
              dmem_be       <= store_be(ex_funct3, ex_alu_result[1:0]);
              dmem_wdata    <= ex_mem_write ? store_wdata(ex_funct3, ex_store_data) : '0;
              state         <= REQ;
            end
          end
        end
        // p1: hold the request until granted
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              mem_valid      <= 1'b1;
              mem_rd         <= rd_p0;
              mem_wr_enable  <= 1'b0;
              mem_mem_to_reg <= mem_to_reg_p0;
              mem_alu_result <= alu_p0;
              mem_exc        <= 1'b0;
              state          <= IDLE;
            end else begin
              state <= RESP;
            end
          end
        end
        // p2: wait for read data and retire the load
        RESP: begin
          if (dmem_rvalid) begin
            mem_valid      <= 1'b1;
            mem_rd         <= rd_p0;
            mem_wr_enable  <= wr_en_p0;
            mem_mem_to_reg <= mem_to_reg_p0;
            mem_alu_result <= alu_p0;
            mem_read_data  <= load_format(funct3_p0, alu_p0[1:0], dmem_rdata);
            mem_exc        <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
